// File: rtl/alu_pkg.sv
// Shared op-code and flag definitions for the TessiaX signed ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110,
      ALU_SRA = 4'b0111,
      ALU_DIV = 4'b1000,
      ALU_MOD = 4'b1001,
      ALU_MUL = 4'b1010
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the issuing stage and the ALU.
interface alu_if #(parameter int N = 6);
   // valid-only flow: valid_in qualifies a/b/ctrl for one edge; there is no
   // back-pressure. valid_out pulses for one cycle when result/flags update.
   logic         valid_in;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   ctrl;
   logic [N-1:0] result;
   logic [3:0]   flags;
   logic         valid_out;

   modport master (output valid_in, a, b, ctrl, input result, flags, valid_out);
   modport slave  (input valid_in, a, b, ctrl, output result, flags, valid_out);
endinterface

// File: rtl/alu_divider.sv
// Combinational signed divide/remainder, truncating toward zero.
module alu_divider #(
   parameter int N = 6
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] quot,
   output logic [N-1:0] rem,
   output logic         div_zero,
   output logic         quot_ovf
);

   logic [N:0] a_ext, b_ext, abs_a, abs_b, divisor, q_mag, q_ext;

   assign div_zero = (b == '0);

   // One extra bit so the magnitude of the most negative value is representable.
   assign a_ext   = {a[N-1], a};
   assign b_ext   = {b[N-1], b};
   assign abs_a   = a[N-1] ? -a_ext : a_ext;
   assign abs_b   = b[N-1] ? -b_ext : b_ext;
   assign divisor = div_zero ? {{N{1'b0}}, 1'b1} : abs_b;
   assign q_mag   = abs_a / divisor;
   assign q_ext   = (a[N-1] ^ b[N-1]) ? -q_mag : q_mag;

   // Only min / -1 produces a quotient that does not fit in N signed bits.
   assign quot_ovf = !div_zero && (q_ext[N] != q_ext[N-1]);
   assign quot     = div_zero ? '0 : q_ext[N-1:0];
   assign rem      = div_zero ? '0 : (a - quot * b);

endmodule

// File: rtl/alu.sv
// Signed N-bit ALU: combinational compute core with one registered output stage.
module alu
   import alu_pkg::*;
#(
   parameter int N = 6
) (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   localparam int SHW = $clog2(N);

   logic [N-1:0]   a, b;
   logic [3:0]     ctrl;
   logic [SHW-1:0] sh;
   logic [N:0]     sum_ext, sll_ext;
   logic [N-1:0]   diff;
   logic [N-1:0]   quot, rem;
   logic           div_zero, quot_ovf;

   logic [N-1:0]   r_next;
   logic           c_next, v_next;
   logic [3:0]     f_next;

   logic [N-1:0]   result_q;
   logic [3:0]     flags_q;
   logic           valid_q;

   assign a    = bus.a;
   assign b    = bus.b;
   assign ctrl = bus.ctrl;
   assign sh   = b[SHW-1:0];

   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign diff    = a - b;
   // Bit N of the widened shift holds the last bit pushed out of the top.
   assign sll_ext = {1'b0, a} << sh;

   alu_divider #(.N(N)) u_div (
      .a        (a),
      .b        (b),
      .quot     (quot),
      .rem      (rem),
      .div_zero (div_zero),
      .quot_ovf (quot_ovf)
   );

   always_comb begin
      r_next = '0;
      c_next = 1'b0;
      v_next = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            r_next = sum_ext[N-1:0];
            c_next = sum_ext[N];
            v_next = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
         end
         ALU_SUB: begin
            r_next = diff;
            v_next = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         ALU_AND: r_next = a & b;
         ALU_OR:  r_next = a | b;
         ALU_XOR: r_next = a ^ b;
         ALU_SLL: begin
            r_next = sll_ext[N-1:0];
            c_next = sll_ext[N];
         end
         ALU_SRL: r_next = a >> sh;
         ALU_SRA: r_next = $unsigned($signed(a) >>> sh);
         ALU_DIV: begin
            r_next = quot;
            v_next = div_zero | quot_ovf;
         end
         ALU_MOD: begin
            r_next = rem;
            v_next = div_zero;
         end
         ALU_MUL: r_next = a * b;
         default: r_next = '0;
      endcase
   end

   always_comb begin
      f_next         = 4'b0000;
      f_next[FLAG_N] = r_next[N-1];
      f_next[FLAG_Z] = (r_next == '0);
      f_next[FLAG_C] = c_next;
      f_next[FLAG_V] = v_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= 4'b0000;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.valid_in;
         if (bus.valid_in) begin
            result_q <= r_next;
            flags_q  <= f_next;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu (N=6): each vector is driven on a falling edge and checked after the next rising edge.
module tb_alu;

   localparam int N = 6;
   localparam int W = 1 + 4 + N;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   logic [W-1:0] exp_q[$];
   logic [N-1:0] last_r;
   logic [3:0]   last_f;

   alu_if #(.N(N)) bus ();

   alu #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag);
      logic [W-1:0] obs;
      logic [W-1:0] exp;
      obs = {bus.valid_out, bus.flags, bus.result};
      exp = exp_q.pop_front();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got v/flags/result %b_%b_%b want %b_%b_%b", tag,
                obs[W-1], obs[W-2 -: 4], obs[N-1:0], exp[W-1], exp[W-2 -: 4], exp[N-1:0]);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] op,
                       input logic [N-1:0] va, input logic [N-1:0] vb,
                       input logic [N-1:0] er, input logic [3:0] ef);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.ctrl     = op;
      bus.a        = va;
      bus.b        = vb;
      exp_q.push_back({1'b1, ef, er});
      last_r = er;
      last_f = ef;
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic idle(input string tag);
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.a        = 6'($urandom_range(0, 63));
      bus.b        = 6'($urandom_range(0, 63));
      exp_q.push_back({1'b0, last_f, last_r});
      @(posedge clk);
      #1;
      check(tag);
   endtask

   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [N-1:0] ma,
                                          input logic [N-1:0] mb);
      int sa, sb, full;
      logic [N-1:0] r;
      logic c, v;
      sa = $signed(ma);
      sb = $signed(mb);
      full = 0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'b0000: begin
            full = sa + sb;
            r = full[N-1:0];
            c = (int'(ma) + int'(mb)) > 63;
            v = (full > 31) || (full < -32);
         end
         4'b0001: begin
            full = sa - sb;
            r = full[N-1:0];
            v = (full > 31) || (full < -32);
         end
         4'b0010: r = ma & mb;
         4'b0011: r = ma | mb;
         default: r = ma ^ mb;
      endcase
      return {1'b1, r[N-1], (r == 6'd0), c, v, r};
   endfunction

   initial begin
      logic [3:0]   rop;
      logic [N-1:0] ra, rb;
      logic [W-1:0] rexp;

      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      bus.ctrl     = 4'b0000;
      bus.a        = '0;
      bus.b        = '0;
      last_r       = '0;
      last_f       = 4'b0000;

      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 4'b0000, 6'b000000});
      check("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 4'b0000, 6'b000000});
      check("post_reset_hold");

      step("sub_neg",      4'b0001, 6'b001010, 6'b010100, 6'b110110, 4'b1000);
      step("sub_pos",      4'b0001, 6'b010100, 6'b001010, 6'b001010, 4'b0000);
      step("sub_ovf",      4'b0001, 6'b100000, 6'b000001, 6'b011111, 4'b0001);
      step("div_trunc",    4'b1000, 6'b111111, 6'b000010, 6'b000000, 4'b0100);
      step("div_min_m1",   4'b1000, 6'b100000, 6'b111111, 6'b100000, 4'b1001);
      step("div_zero",     4'b1000, 6'b000101, 6'b000000, 6'b000000, 4'b0101);
      step("div_neg",      4'b1000, 6'b111001, 6'b000010, 6'b111101, 4'b1000);
      step("div_negb",     4'b1000, 6'b010100, 6'b111101, 6'b111010, 4'b1000);
      step("mod_nega",     4'b1001, 6'b111001, 6'b000010, 6'b111111, 4'b1000);
      step("mod_negb",     4'b1001, 6'b000111, 6'b111110, 6'b000001, 4'b0000);
      step("mod_zero",     4'b1001, 6'b010101, 6'b000000, 6'b000000, 4'b0101);
      step("mod_min_m1",   4'b1001, 6'b100000, 6'b111111, 6'b000000, 4'b0100);
      step("add_ovf",      4'b0000, 6'b011111, 6'b000001, 6'b100000, 4'b1001);
      step("add_carry",    4'b0000, 6'b111111, 6'b000001, 6'b000000, 4'b0110);
      step("and",          4'b0010, 6'b101100, 6'b110110, 6'b100100, 4'b1000);
      step("or",           4'b0011, 6'b001100, 6'b000011, 6'b001111, 4'b0000);
      step("xor_self",     4'b0100, 6'b101010, 6'b101010, 6'b000000, 4'b0100);
      step("sll_carry",    4'b0101, 6'b100001, 6'b000001, 6'b000010, 4'b0010);
      step("sll_3",        4'b0101, 6'b000101, 6'b000011, 6'b101000, 4'b1000);
      step("sll_over",     4'b0101, 6'b000000, 6'b000110, 6'b000000, 4'b0100);
      step("srl_2",        4'b0110, 6'b100000, 6'b000010, 6'b001000, 4'b0000);
      step("srl_over",     4'b0110, 6'b111111, 6'b000110, 6'b000000, 4'b0100);
      step("sra_2",        4'b0111, 6'b100000, 6'b000010, 6'b111000, 4'b1000);
      step("sra_over",     4'b0111, 6'b100100, 6'b000111, 6'b111111, 4'b1000);
      step("mul_neg",      4'b1010, 6'b000011, 6'b111011, 6'b110001, 4'b1000);
      step("mul_wrap",     4'b1010, 6'b001000, 6'b001000, 6'b000000, 4'b0100);
      step("undef_1011",   4'b1011, 6'b010101, 6'b001100, 6'b000000, 4'b0100);
      step("undef_1111",   4'b1111, 6'b111111, 6'b111111, 6'b000000, 4'b0100);

      step("pre_hold",     4'b0000, 6'b000011, 6'b000100, 6'b000111, 4'b0000);
      idle("hold_1");
      idle("hold_2");
      idle("hold_3");

      for (int i = 0; i < 16; i++) begin
         rop  = 4'($urandom_range(0, 4));
         ra   = 6'($urandom_range(0, 63));
         rb   = 6'($urandom_range(0, 63));
         rexp = model(rop, ra, rb);
         step("rand_op", rop, ra, rb, rexp[N-1:0], rexp[W-2 -: 4]);
      end

      step("pre_reset",    4'b0000, 6'b010000, 6'b001000, 6'b011000, 4'b0000);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.ctrl     = 4'b0011;
      bus.a        = 6'b101010;
      bus.b        = 6'b010101;
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.push_back({1'b0, 4'b0000, 6'b000000});
      check("async_reset");
      @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 4'b0000, 6'b000000});
      check("reset_discard");
      @(negedge clk);
      bus.valid_in = 1'b0;
      rst_n        = 1'b1;
      last_r       = '0;
      last_f       = 4'b0000;
      idle("reset_release");
      step("after_reset",  4'b0001, 6'b000000, 6'b000001, 6'b111111, 4'b1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
